// File: rtl/arb_pkg.sv
// Shared constants, state type and round-robin search for rr_arb8_ctrl.
// Search order starts just after the last winner and wraps.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_t;

  // Returns {found, idx}; ptr+1 has highest priority, ptr itself lowest.
  function automatic logic [IDX_W:0] next_rr(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr,
    input logic [N_REQ-1:0] excl
  );
    logic [N_REQ-1:0] cand;
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] k;
    cand = req & ~excl;
    res  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = ptr + i[IDX_W-1:0];
      if (cand[k]) res = {1'b1, k};
    end
    return res;
  endfunction

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decoder with enable.
// Output is all zero when en is low.
module onehot_dec3 (
  input  logic [2:0] in,
  input  logic       en,
  output logic [7:0] out
);

  assign out = en ? (8'h01 << in) : 8'h00;

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Eight-way round-robin arbiter with grant held until release.
// Optional forced release after MAX_HOLD cycles: define RR_TIMEOUT_EN.
module rr_arb8_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       to_pulse
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] excl;
  logic [IDX_W:0]   pick;
  logic             found;
  logic [IDX_W-1:0] win;

  always_comb begin
    excl = '0;
    if (state == GRANT) excl[gnt_idx] = 1'b1;
  end

  assign pick  = next_rr(req, ptr, excl);
  assign found = pick[IDX_W];
  assign win   = pick[IDX_W-1:0];

  assign gnt_vld = (state == GRANT);

  onehot_dec3 u_dec (
    .in  (gnt_idx),
    .en  (gnt_vld),
    .out (gnt)
  );

`ifdef RR_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             to_r;
  assign to_pulse = to_r;
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_LIM;
  assign to_pulse    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      ptr     <= 3'd7;
`ifdef RR_TIMEOUT_EN
      cnt     <= '0;
      to_r    <= 1'b0;
`endif
    end else begin
`ifdef RR_TIMEOUT_EN
      to_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            gnt_idx <= win;
            ptr     <= win;
`ifdef RR_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        GRANT: begin
          if (!req[gnt_idx]) begin
            if (found) begin
              gnt_idx <= win;
              ptr     <= win;
            end else begin
              state <= IDLE;
            end
`ifdef RR_TIMEOUT_EN
            cnt <= '0;
`endif
          end
`ifdef RR_TIMEOUT_EN
          else if (cnt == HOLD_LIM) begin
            // Forced release; a lone requester keeps its index.
            to_r <= 1'b1;
            cnt  <= '0;
            if (found) begin
              gnt_idx <= win;
              ptr     <= win;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed bench for rr_arb8_ctrl with hand-computed grants.
// Timeout scenario runs only when RR_TIMEOUT_EN is defined.
module tb_rr_arb8_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       to_pulse;

  int checks;
  int failures;

  rr_arb8_ctrl #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld),
    .to_pulse (to_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 8'h00;

    // T1: reset and idle
    step();
    step();
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_vld", gnt_vld, 1'b0);
    chk("rst_idx", gnt_idx, 3'd0);
    chk("rst_to", to_pulse, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_gnt", gnt, 8'h00);
      chk("idle_vld", gnt_vld, 1'b0);
      chk("idle_to", to_pulse, 1'b0);
    end

    // T2: two requesters, release chain
    req = 8'h81;
    step();
    chk("t2_gnt0", gnt, 8'h01);
    chk("t2_idx0", gnt_idx, 3'd0);
    chk("t2_vld0", gnt_vld, 1'b1);
    req = 8'h80;
    step();
    chk("t2_gnt7", gnt, 8'h80);
    chk("t2_idx7", gnt_idx, 3'd7);
    req = 8'h00;
    step();
    chk("t2_idle", gnt, 8'h00);
    chk("t2_vld", gnt_vld, 1'b0);

    // T3: all request, each holder drops for one cycle
    req = 8'hFF;
    step();
    for (int k = 0; k <= 8; k++) begin
      chk("t3_gnt", gnt, 32'h1 << (k % 8));
      chk("t3_vld", gnt_vld, 1'b1);
      if (k < 8) begin
        req = ~(8'h01 << k);
        step();
        req = 8'hFF;
      end
    end
    req = 8'h00;
    step();
    chk("t3_idle", gnt_vld, 1'b0);

    // T4: no pre-emption of a held grant
    req = 8'h04;
    step();
    chk("t4_gnt2", gnt, 8'h04);
    req = 8'h14;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold", gnt, 8'h04);
    end
    req = 8'h10;
    step();
    chk("t4_gnt4", gnt, 8'h10);
    chk("t4_idx4", gnt_idx, 3'd4);
    req = 8'h00;
    step();
    chk("t4_idle", gnt, 8'h00);

`ifdef RR_TIMEOUT_EN
    // T5: forced release after four cycles
    req = 8'h09;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_gnt0", gnt, 8'h01);
      chk("t5_to0", to_pulse, 1'b0);
    end
    step();
    chk("t5_gnt3", gnt, 8'h08);
    chk("t5_to1", to_pulse, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold3", gnt, 8'h08);
      chk("t5_to_lo", to_pulse, 1'b0);
    end
    step();
    chk("t5_back0", gnt, 8'h01);
    chk("t5_to2", to_pulse, 1'b1);
    req = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_solo", gnt, 8'h01);
      chk("t5_solo_to", to_pulse, 1'b0);
    end
    step();
    chk("t5_regnt", gnt, 8'h01);
    chk("t5_regnt_to", to_pulse, 1'b1);
    step();
    chk("t5_to_clr", to_pulse, 1'b0);
`else
    // Without timeout a grant is held indefinitely
    req = 8'h09;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("hold_gnt", gnt, 8'h01);
      chk("hold_to", to_pulse, 1'b0);
    end
`endif
    req = 8'h00;
    step();
    chk("pre6_idle", gnt_vld, 1'b0);

    // T6: reset mid-grant restores pointer
    req = 8'h20;
    step();
    chk("t6_gnt5", gnt, 8'h20);
    rst = 1'b1;
    step();
    chk("t6_rst_gnt", gnt, 8'h00);
    chk("t6_rst_vld", gnt_vld, 1'b0);
    chk("t6_rst_to", to_pulse, 1'b0);
    rst = 1'b0;
    req = 8'h21;
    step();
    chk("t6_gnt0", gnt, 8'h01);
    chk("t6_idx0", gnt_idx, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
